// File: rtl/ahb_arbiter_2m.sv
// Round-robin arbiter for two AHB masters; honours fixed bursts, INCR and locked tenures.
// Latency: HGRANT moves on the arbitration-point edge, HMASTER follows on the next HREADY=1 edge.
// Backpressure: every register holds while HREADY = 0; the grant never moves mid-tenure.
module ahb_arbiter_2m #(
  parameter logic DEFAULT_MASTER = 1'b0
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HBUSREQ0,
  input  logic       HBUSREQ1,
  input  logic       HMASTLOCK0,
  input  logic       HMASTLOCK1,
  input  logic [1:0] HTRANS0,
  input  logic [1:0] HTRANS1,
  input  logic [2:0] HBURST0,
  input  logic [2:0] HBURST1,
  input  logic       HREADY,
  output logic       HGRANT0,
  output logic       HGRANT1,
  output logic       HMASTER,
  output logic       HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR = 3'b001;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BURST  = 2'd1,
    INCR   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] beats_q, beats_d;
  logic       gnt_q, gnt_d;      // granted master index; HGRANT0/1 are its one-hot decode
  logic       master_q;          // address-phase owner
  logic       lock_q;

  logic [1:0] own_trans;
  logic [2:0] own_burst;
  logic       own_lock;
  logic       own_req;
  logic [3:0] first_remaining;

  // Beats still owed after the NONSEQ of a fixed-length burst (0 for SINGLE and INCR).
  function automatic logic [3:0] remaining_after_first(input logic [2:0] burst);
    logic [3:0] rem;
    rem = 4'd0;
    case (burst[2:1])
      2'b00:   rem = 4'd0;
      2'b01:   rem = 4'd3;
      2'b10:   rem = 4'd7;
      default: rem = 4'd15;
    endcase
    return rem;
  endfunction

  // Select the owner's transfer-control inputs.
  always_comb begin
    own_trans = HTRANS0;
    own_burst = HBURST0;
    own_lock  = HMASTLOCK0;
    own_req   = HBUSREQ0;
    if (master_q) begin
      own_trans = HTRANS1;
      own_burst = HBURST1;
      own_lock  = HMASTLOCK1;
      own_req   = HBUSREQ1;
    end
    first_remaining = remaining_after_first(own_burst);
  end

  // Tenure tracking: next state and beat count from the owner's current address phase.
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    case (state_q)
      FREE: begin
        // A stray SEQ here is ignored; only NONSEQ opens a tenure, lock winning over length.
        if (own_trans == TR_NONSEQ) begin
          if (own_lock) begin
            state_d = LOCKED;
          end else if (own_burst == BURST_INCR) begin
            state_d = INCR;
          end else if (first_remaining != 4'd0) begin
            state_d = BURST;
            beats_d = first_remaining;
          end
        end
      end
      BURST: begin
        case (own_trans)
          TR_SEQ: begin
            // Counter saturates at zero; the last SEQ closes the tenure.
            if (beats_q <= 4'd1) begin
              state_d = FREE;
              beats_d = 4'd0;
            end else begin
              beats_d = beats_q - 4'd1;
            end
          end
          TR_BUSY: begin
            state_d = BURST;
          end
          default: begin
            // IDLE or NONSEQ mid-burst ends the burst early.
            state_d = FREE;
            beats_d = 4'd0;
          end
        endcase
      end
      INCR: begin
        if (!(((own_trans == TR_SEQ) || (own_trans == TR_BUSY)) && own_req)) begin
          state_d = FREE;
        end
      end
      LOCKED: begin
        if (!own_lock) begin
          state_d = FREE;
        end
      end
      default: begin
        state_d = FREE;
        beats_d = 4'd0;
      end
    endcase
  end

  // Round-robin grant decision, applied only where the tenure ends on this edge.
  always_comb begin
    gnt_d = gnt_q;
    if (state_d == FREE) begin
      case ({HBUSREQ1, HBUSREQ0})
        2'b11:   gnt_d = ~master_q;
        2'b10:   gnt_d = 1'b1;
        2'b01:   gnt_d = 1'b0;
        default: gnt_d = DEFAULT_MASTER;
      endcase
    end
  end

  // All state advances only on HREADY edges; reset aborts any tenure at once.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= FREE;
      beats_q  <= 4'd0;
      gnt_q    <= DEFAULT_MASTER;
      master_q <= DEFAULT_MASTER;
      lock_q   <= 1'b0;
    end else if (HREADY) begin
      state_q  <= state_d;
      beats_q  <= beats_d;
      gnt_q    <= gnt_d;
      master_q <= gnt_q;
      lock_q   <= own_lock;
    end
  end

  assign HGRANT0   = ~gnt_q;
  assign HGRANT1   = gnt_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = lock_q;

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Directed vector bench for ahb_arbiter_2m (DEFAULT_MASTER = 0).
// Expected outputs are packed as {HGRANT0, HGRANT1, HMASTER, HMASTLOCK} after each edge.
// Inputs change #1 after the rising edge, outputs are sampled there too.
module tb_ahb_arbiter_2m;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] BSY = 2'b01;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
  localparam logic [2:0] SGL = 3'b000;
  localparam logic [2:0] BI  = 3'b001;
  localparam logic [2:0] W4  = 3'b010;
  localparam logic [2:0] B4  = 3'b011;
  localparam logic [2:0] B8  = 3'b101;

  logic       HCLK, HRESET;
  logic       HBUSREQ0, HBUSREQ1, HMASTLOCK0, HMASTLOCK1, HREADY;
  logic [1:0] HTRANS0, HTRANS1;
  logic [2:0] HBURST0, HBURST1;
  logic       HGRANT0, HGRANT1, HMASTER, HMASTLOCK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       r0, r1, l0, l1;
    logic [1:0] t0, t1;
    logic [2:0] b0, b1;
    logic       rdy;
    logic [3:0] exp;
  } vec_t;

  vec_t vq[$];

  ahb_arbiter_2m #(.DEFAULT_MASTER(1'b0)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HBUSREQ0(HBUSREQ0), .HBUSREQ1(HBUSREQ1),
    .HMASTLOCK0(HMASTLOCK0), .HMASTLOCK1(HMASTLOCK1),
    .HTRANS0(HTRANS0), .HTRANS1(HTRANS1),
    .HBURST0(HBURST0), .HBURST1(HBURST1),
    .HREADY(HREADY),
    .HGRANT0(HGRANT0), .HGRANT1(HGRANT1),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  task automatic add(input logic r0, r1, l0, l1, input logic [1:0] t0, t1,
                     input logic [2:0] b0, b1, input logic rdy, input logic [3:0] exp);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.l0 = l0; v.l1 = l1;
    v.t0 = t0; v.t1 = t1; v.b0 = b0; v.b1 = b1;
    v.rdy = rdy; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    HBUSREQ0 = v.r0; HBUSREQ1 = v.r1;
    HMASTLOCK0 = v.l0; HMASTLOCK1 = v.l1;
    HTRANS0 = v.t0; HTRANS1 = v.t1;
    HBURST0 = v.b0; HBURST1 = v.b1;
    HREADY = v.rdy;
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {HGRANT0, HGRANT1, HMASTER, HMASTLOCK};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got g0/g1/master/lock=%b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    vec_t idle;
    idle = '{r0:0, r1:0, l0:0, l1:0, t0:IDL, t1:IDL, b0:SGL, b1:SGL, rdy:1, exp:4'b1000};

    // Master 1 alone, then master 0 takes it back at the next arbitration point.
    add(0,1,0,0, IDL,IDL, SGL,SGL, 1, 4'b0100);
    add(0,1,0,0, IDL,IDL, SGL,SGL, 1, 4'b0110);
    add(0,1,0,0, IDL,NSQ, SGL,SGL, 1, 4'b0110);
    add(1,1,0,0, IDL,NSQ, SGL,SGL, 1, 4'b1010);
    add(1,0,0,0, IDL,IDL, SGL,SGL, 1, 4'b1000);
    // INCR8 by master 0, master 1 requesting from beat 2.
    add(1,0,0,0, NSQ,IDL, B8,SGL, 1, 4'b1000);
    for (int i = 0; i < 6; i++) add(1,1,0,0, SQ,IDL, B8,SGL, 1, 4'b1000);
    add(1,1,0,0, SQ,IDL, B8,SGL, 1, 4'b0100);
    add(0,1,0,0, IDL,IDL, SGL,SGL, 1, 4'b0110);
    add(0,0,0,0, IDL,IDL, SGL,SGL, 1, 4'b1010);
    add(0,0,0,0, IDL,IDL, SGL,SGL, 1, 4'b1000);
    // Same INCR8 with a 3-cycle stall on beat 4.
    add(1,0,0,0, NSQ,IDL, B8,SGL, 1, 4'b1000);
    for (int i = 0; i < 2; i++) add(1,1,0,0, SQ,IDL, B8,SGL, 1, 4'b1000);
    for (int i = 0; i < 3; i++) add(1,1,0,0, SQ,IDL, B8,SGL, 0, 4'b1000);
    for (int i = 0; i < 4; i++) add(1,1,0,0, SQ,IDL, B8,SGL, 1, 4'b1000);
    add(1,1,0,0, SQ,IDL, B8,SGL, 1, 4'b0100);
    add(0,1,0,0, IDL,IDL, SGL,SGL, 0, 4'b0100);
    add(0,1,0,0, IDL,IDL, SGL,SGL, 1, 4'b0110);
    // Master 1 locked across two INCR4 bursts, master 0 requesting.
    add(1,1,0,1, IDL,NSQ, SGL,B4, 1, 4'b0111);
    for (int i = 0; i < 3; i++) add(1,1,0,1, IDL,SQ, SGL,B4, 1, 4'b0111);
    add(1,1,0,1, IDL,NSQ, SGL,B4, 1, 4'b0111);
    for (int i = 0; i < 3; i++) add(1,1,0,1, IDL,SQ, SGL,B4, 1, 4'b0111);
    add(1,0,0,0, IDL,IDL, SGL,SGL, 0, 4'b0111);
    add(1,0,0,0, IDL,IDL, SGL,SGL, 1, 4'b1010);
    add(1,0,0,0, IDL,IDL, SGL,SGL, 1, 4'b1000);
    // Both request SINGLEs: round-robin alternation, then back to default.
    add(1,1,0,0, NSQ,NSQ, SGL,SGL, 1, 4'b0100);
    add(1,1,0,0, NSQ,NSQ, SGL,SGL, 1, 4'b0110);
    add(1,1,0,0, NSQ,NSQ, SGL,SGL, 1, 4'b1010);
    add(1,1,0,0, NSQ,NSQ, SGL,SGL, 1, 4'b1000);
    add(1,1,0,0, NSQ,NSQ, SGL,SGL, 1, 4'b0100);
    add(1,1,0,0, NSQ,NSQ, SGL,SGL, 1, 4'b0110);
    add(0,0,0,0, IDL,IDL, SGL,SGL, 1, 4'b1010);
    add(0,0,0,0, IDL,IDL, SGL,SGL, 1, 4'b1000);
    // Undefined-length INCR: held through SEQ/BUSY, released when the owner drops its request.
    add(1,1,0,0, NSQ,IDL, BI,SGL, 1, 4'b1000);
    add(1,1,0,0, SQ,IDL,  BI,SGL, 1, 4'b1000);
    add(1,1,0,0, BSY,IDL, BI,SGL, 1, 4'b1000);
    add(0,1,0,0, SQ,IDL,  BI,SGL, 1, 4'b0100);
    add(0,1,0,0, IDL,IDL, SGL,SGL, 1, 4'b0110);
    // SEQ while FREE is ignored: arbitration still happens.
    add(1,1,0,0, IDL,SQ,  SGL,B4, 1, 4'b1010);
    add(1,0,0,0, IDL,IDL, SGL,SGL, 1, 4'b1000);
    // WRAP4 terminated early by IDLE.
    add(1,1,0,0, NSQ,IDL, W4,SGL, 1, 4'b1000);
    add(1,1,0,0, SQ,IDL,  W4,SGL, 1, 4'b1000);
    add(1,1,0,0, IDL,IDL, SGL,SGL, 1, 4'b0100);
    add(0,1,0,0, IDL,IDL, SGL,SGL, 1, 4'b0110);

    // Reset state, before and after the first edges.
    drive(idle);
    HRESET = 1'b1;
    #1 check("reset_initial", 4'b1000);
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge HCLK); #1;
      check($sformatf("idle_cycle%0d", i), 4'b1000);
    end

    foreach (vq[i]) begin
      drive(vq[i]);
      @(posedge HCLK); #1;
      check($sformatf("vec%0d", i), vq[i].exp);
    end

    // Enter a locked tenure as master 1, then reset asynchronously between edges.
    drive('{r0:0, r1:1, l0:0, l1:1, t0:IDL, t1:NSQ, b0:SGL, b1:SGL, rdy:1, exp:4'b0111});
    @(posedge HCLK); #1;
    check("locked_before_reset", 4'b0111);
    #3 HRESET = 1'b1;
    #1 check("async_reset", 4'b1000);
    @(posedge HCLK); #1;
    check("reset_held", 4'b1000);
    HRESET = 1'b0;
    drive('{r0:0, r1:1, l0:0, l1:0, t0:IDL, t1:IDL, b0:SGL, b1:SGL, rdy:1, exp:4'b0100});
    @(posedge HCLK); #1;
    check("after_reset_arb", 4'b0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
